alu_flag_unit: RTL
==================

Name: alu_flag_unit

Overview:
- Owns the architectural status flags {neg, zero, carry, overflow} for the VLIW datapath.
- Captures flags retired by the ALU lanes at writeback and feeds the carry flag back as ALU carry-in.
- Serves branch-condition queries from the branch unit over a valid/ready handshake.
- Stalls queries while flag-setting ops are in flight (pending-writer scoreboard).

Parameters:
NUM_LANES, 2, number of ALU issue slots retiring per cycle
PEND_W, 3, width of in-flight flag-writer counter (max 2^PEND_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
issue_setflags  in  1  one flag-setting ALU op issued this cycle
wb_valid  in  NUM_LANES  lane i retires an op
wb_setflags  in  NUM_LANES  retiring op on lane i writes flags
wb_neg, wb_zero, wb_carry, wb_overflow  in  NUM_LANES each  per-lane ALU flag results
carry_out  out  1  carry-in to ALU (iCarry)
flags_out  out  4  {neg,zero,carry,overflow} architectural flags
cond_req_valid  in  1  branch query valid
cond_req_ready  out  1  query accepted when valid&ready
cond_code  in  4  condition selector
cond_resp_valid  out  1  one-cycle pulse, result valid
cond_taken  out  1  condition result, meaningful only with cond_resp_valid
pend_err  out  1  sticky scoreboard under/overflow error

Behaviour:
- Reset (async, rst=1): flags=0, pending=0, state=IDLE, cond_resp_valid=0, cond_taken=0, pend_err=0, latched code=0; cond_req_ready=1 after release.
- Flag write: lane retires flags when wb_valid[i]&wb_setflags[i]. Highest-index such lane wins (program order within a bundle). Flags update at the clock edge; none retiring → hold.
- Pending counter: next = pending + issue_setflags − popcount(wb_valid&wb_setflags).
  - Result >2^PEND_W−1: saturate at max, set pend_err.
  - Result <0: clamp to 0, set pend_err.
  - pend_err clears only on rst.
- FSM:
  - IDLE: cond_req_ready=1. On accept, latch cond_code. Go to EVAL if next-pending==0, else WAIT.
  - WAIT: cond_req_ready=0. Go to EVAL when next-pending==0. The wait is conservative: it also covers writers issued after the query was accepted.
  - EVAL: cond_req_ready=0. cond_resp_valid=1 for exactly one cycle. cond_taken=cond_eval(latched code, flags register). Always return to IDLE.
- Latency: accept at edge k with no pending writers → response valid during the cycle after edge k+1. Throughput: one query per 2 cycles.
- Same cycle as accept:
  - Retirement of the last pending writer → EVAL uses the updated flags.
  - issue_setflags → counted, so the query goes to WAIT.
- Condition codes (ARM order 0–15): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
- cond_req_valid low in IDLE: no state change. Withdrawing valid before ready is permitted.
- carry_out = registered carry flag.
- rst mid-query: query is dropped and no response is issued.

Optional Feature:
CARRY_FWD_EN
- Defined: carry_out is forwarded combinationally from the winning lane's wb_carry in the retiring cycle. Back-to-back add-with-carry chains then run without a bubble.
- Undefined: carry_out is the registered flag, one cycle later.
- flags_out is registered in both cases.

Decomposition:
- Package alu_flag_pkg holds:
  - cond-code localparams (COND_EQ..COND_NV)
  - flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0)
  - FSM state enum (IDLE, WAIT, EVAL)
- Sub-module alu_cond_eval: purely combinational, cond_code + 4 flags → taken. Reused by the branch predictor checker.

Test Plan:
- Reset then query EQ with no writers → response in 2nd cycle after accept, taken=0. Retire lane0 zero=1, then query EQ → taken=1.
- Issue 2 setflags, query GE at once → ready drops. Retire lane0 {N=1,V=0}, then lane1 {N=1,V=1} → response only after the 2nd retirement, taken=1.
- Same-bundle retire: lane0 Z=1, lane1 Z=0, both setflags → flags_out Z=0 (lane1 wins).
- Carry feedback: retire carry=1 at edge k. Without CARRY_FWD_EN, carry_out=1 from cycle k+1. With it, carry_out=1 during cycle k.
- Underflow: retire setflags with pending=0 → pending stays 0, pend_err=1 and stays set until rst.
- Assert rst in WAIT state → no cond_resp_valid; ready=1 and flags=0 after release.

Source files
------------

// File: rtl/alu_flag_pkg.sv
// Shared definitions for the architectural flag unit: condition codes, flag bit
// positions and the branch-query state encoding.
package alu_flag_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational ARM-style condition evaluator; also used by the branch
// predictor checker, so it must stay free of state.
module alu_cond_eval
  import alu_flag_pkg::*;
(
  input  logic [3:0] cond_code_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic n, z, c, v;

  assign n = flags_i[FLG_N];
  assign z = flags_i[FLG_Z];
  assign c = flags_i[FLG_C];
  assign v = flags_i[FLG_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_code_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c & !z;
      COND_LS: taken_o = !c | z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z & (n == v);
      COND_LE: taken_o = z | (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Architectural {N,Z,C,V} flag owner with pending-writer scoreboard and branch
// condition query port. Define CARRY_FWD_EN to forward retiring carry to carry_out.
module alu_flag_unit
  import alu_flag_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int PEND_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_setflags,
  input  logic [NUM_LANES-1:0] wb_valid,
  input  logic [NUM_LANES-1:0] wb_setflags,
  input  logic [NUM_LANES-1:0] wb_neg,
  input  logic [NUM_LANES-1:0] wb_zero,
  input  logic [NUM_LANES-1:0] wb_carry,
  input  logic [NUM_LANES-1:0] wb_overflow,
  output logic                 carry_out,
  output logic [3:0]           flags_out,
  input  logic                 cond_req_valid,
  output logic                 cond_req_ready,
  input  logic [3:0]           cond_code,
  output logic                 cond_resp_valid,
  output logic                 cond_taken,
  output logic                 pend_err
);

  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic [3:0]        flags_q, flags_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pendErr_q, pendErr_d;
  state_e            state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic              respValid_q, respValid_d;
  logic              taken_q, taken_d;
  logic              evalTaken;
  int                retireCnt;
  int                pendSum;

  // Later lanes overwrite earlier ones so the youngest op in the bundle wins.
  always_comb begin
    flags_d   = flags_q;
    retireCnt = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wb_valid[i] && wb_setflags[i]) begin
        flags_d   = {wb_neg[i], wb_zero[i], wb_carry[i], wb_overflow[i]};
        retireCnt = retireCnt + 1;
      end
    end
  end

  always_comb begin
    pendSum   = int'(pend_q) + (issue_setflags ? 1 : 0) - retireCnt;
    pend_d    = PEND_W'(pendSum);
    pendErr_d = pendErr_q;
    if (pendSum > PEND_MAX) begin
      pend_d    = PEND_W'(PEND_MAX);
      pendErr_d = 1'b1;
    end else if (pendSum < 0) begin
      pend_d    = '0;
      pendErr_d = 1'b1;
    end
  end

  alu_cond_eval uCondEval (
    .cond_code_i(code_q),
    .flags_i    (flags_q),
    .taken_o    (evalTaken)
  );

  // Decisions use next-cycle pending so a same-edge last retirement skips WAIT.
  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    respValid_d    = 1'b0;
    taken_d        = 1'b0;
    cond_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cond_req_ready = 1'b1;
        if (cond_req_valid) begin
          code_d  = cond_code;
          state_d = (pend_d == '0) ? EVAL : WAIT;
        end
      end
      WAIT: begin
        if (pend_d == '0) state_d = EVAL;
      end
      EVAL: begin
        respValid_d = 1'b1;
        taken_d     = evalTaken;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      pend_q      <= '0;
      pendErr_q   <= 1'b0;
      state_q     <= IDLE;
      code_q      <= '0;
      respValid_q <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      pend_q      <= pend_d;
      pendErr_q   <= pendErr_d;
      state_q     <= state_d;
      code_q      <= code_d;
      respValid_q <= respValid_d;
      taken_q     <= taken_d;
    end
  end

  assign flags_out       = flags_q;
  assign pend_err        = pendErr_q;
  assign cond_resp_valid = respValid_q;
  assign cond_taken      = taken_q;

`ifdef CARRY_FWD_EN
  assign carry_out = flags_d[FLG_C];
`else
  assign carry_out = flags_q[FLG_C];
`endif

endmodule
